mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit holding architectural HI/LO registers.
- Successor to the single-cycle integer ALU: adds signed/unsigned mult/div, configurable latency, busy handshake and HI/LO writes.
- Sits in the EX stage beside the ALU.
- Pipeline control stalls HI/LO-dependent instructions while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles busy for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy for DIV/DIVU (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled at rising edge.
- mdu_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- a  input  WIDTH  rs operand / dividend / MTHI-MTLO source.
- b  input  WIDTH  rt operand / divisor.
- busy  output  1  operation in flight.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result=0. Any in-flight operation is aborted and its result discarded.
- States: IDLE, RUN (implementation may use busy as the state bit).

IDLE, start=1, op in {1,2,3,4}:
- At the edge: compute the full result into pending_hi/pending_lo.
- Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); busy<=1; go RUN.
- hi/lo remain unchanged.

IDLE, start=1, op 5/6:
- hi<=a (MTHI) or lo<=a (MTLO) at that edge; busy stays 0.

IDLE, start=0 or op in {0,7}: no change.

RUN, each edge:
- Counter decrements.
- At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, go IDLE.
- busy is high for exactly N cycles. New hi/lo are visible in the cycle busy reads 0.

start while busy: ignored entirely (no requeue, no MTHI/MTLO). Control must not issue it.

Arithmetic:
- MULT: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower.
- MULTU: unsigned product, same split.
- DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b==0, DIV or DIVU): operation still runs DIV_CYCLES with busy; hi/lo are left unchanged at completion.
- Signed overflow (a=min negative, b=-1): lo=min negative, hi=0.

Operands are captured at the start edge. Changes to a/b during RUN have no effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> busy=0, hi=0, lo=0. Assert reset=0 mid-RUN -> busy drops immediately (asynchronous), hi/lo=0, no later commit.
- MULT a=0xFFFFFFFE (-2), b=3, start=1 one cycle -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- Boundary: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU by 0 with hi=0x11, lo=0x22 preloaded -> busy 10 cycles, then hi=0x11, lo=0x22.
- MTHI a=0xDEADBEEF then MTLO a=0x12345678 on consecutive cycles -> hi=0xDEADBEEF after the first edge, lo=0x12345678 after the second, busy never asserts.
- start MULT 2*3, then MTLO a=0x99 issued while busy, and a/b changed during RUN -> the MTLO is ignored; final lo=6, hi=0.

Source files
------------

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// The full result is computed at the start edge; busy then runs for a fixed count before HI/LO commit.
module mdu_iter #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic             r_pend_we;

    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic signed [WIDTH-1:0]   w_as, w_bs;
    logic                      w_b_zero, w_b_neg1;
    logic        [WIDTH-1:0]   w_b_safe;
    logic        [WIDTH-1:0]   w_res_hi, w_res_lo;
    logic                      w_res_we;

    assign w_as     = $signed(a);
    assign w_bs     = $signed(w_b_safe);
    assign w_b_zero = (b == '0);
    assign w_b_neg1 = (b == '1);
    // Substitute a divisor of 1 so the divider never sees zero; the result is discarded anyway.
    assign w_b_safe = w_b_zero ? WIDTH'(1) : b;
    assign w_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_we = 1'b1;
        case (mdu_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                w_res_we = !w_b_zero;
                // Division by -1 is negation; wrapping the most negative value back onto itself.
                if (w_b_neg1) begin
                    w_res_lo = '0 - a;
                    w_res_hi = '0;
                end else begin
                    w_res_lo = w_as / w_bs;
                    w_res_hi = w_as % w_bs;
                end
            end
            OP_DIVU: begin
                w_res_we = !w_b_zero;
                w_res_lo = a / w_b_safe;
                w_res_hi = a % w_b_safe;
            end
            default: w_res_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (r_pend_we) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (start) begin
            case (mdu_op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    r_pend_hi <= w_res_hi;
                    r_pend_lo <= w_res_lo;
                    r_pend_we <= w_res_we;
                    r_busy    <= 1'b1;
                    r_cnt     <= (mdu_op == OP_MULT || mdu_op == OP_MULTU) ?
                                 CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: r_hi <= a;
                OP_MTLO: r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: each operation is issued, busy length counted, HI/LO compared.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;
    int          n_cmp = 0, n_bad = 0;

    mdu_iter dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else
            $display("ok   %s: 0x%08h", tag, got);
    endtask

    // Drive one start cycle; returns #1 after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1; mdu_op = op; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = 3'd0;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy still reaches the summary.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input int cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        issue(op, va, vb);
        count_busy(n);
        chk({tag, " busy_cycles"}, n, cyc);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        start = 1'b1; mdu_op = 3'd5; a = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("mthi hi", hi, 32'hDEADBEEF);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        mdu_op = 3'd6; a = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = 3'd0;
        chk("mtlo lo", lo, 32'h12345678);
        chk("mtlo hi kept", hi, 32'hDEADBEEF);
        chk("mtlo busy", {31'd0, busy}, 32'd0);

        run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu",  3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run_op("div_pos_neg", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        run_op("divu_by0", 3'd4, 32'd100, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_by0",  3'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22);

        // MTLO and operand changes during RUN must have no effect.
        issue(3'd1, 32'd2, 32'd3);
        start = 1'b1; mdu_op = 3'd6; a = 32'h99; b = 32'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = 3'd0;
        chk("ignore busy_mid", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("ignore busy_rest", n, 3);
        chk("ignore hi", hi, 32'd0);
        chk("ignore lo", lo, 32'd6);

        // Asynchronous reset in the middle of a divide.
        issue(3'd5, 32'hAAAA5555, 32'd0);
        issue(3'd3, 32'd50, 32'd5);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("areset busy", {31'd0, busy}, 32'd0);
        chk("areset hi", hi, 32'd0);
        chk("areset lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("areset no_commit busy", {31'd0, busy}, 32'd0);
        chk("areset no_commit hi", hi, 32'd0);
        chk("areset no_commit lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
